// File: rtl/pc_fetch_ctrl.sv
// pc_fetch_ctrl: program-counter sequencer for the IF stage.
// Three states: RUN (normal fetch), WAIT (control-flow instruction in ID,
// fetch held until the redirect or not-taken resolution arrives) and HALT
// (HLT seen, frozen until reset). All outputs are registered except PC_plus1.
// Optional feature macro: PC_FETCH_WAIT_TIMEOUT_EN adds a 4-bit WAIT cycle
// counter and the sticky wait_timeout flag.
module pc_fetch_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cf_decoded,
  input  logic        alu_done,
  input  logic [15:0] PC_update,
  input  logic        PC_src,
  input  logic        update_done,
  input  logic        hlt_decoded,
  input  logic        stall,
  output logic [15:0] PC,
  output logic [15:0] PC_plus1,
  output logic        fetch_valid,
  output logic        flush_IF_ID,
  output logic        pipe_halt,
  output logic        halted
`ifdef PC_FETCH_WAIT_TIMEOUT_EN
  ,
  output logic        wait_timeout
`endif
);

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_WAIT = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  state_t      state_q;
  logic [15:0] pc_q;
  logic        fetch_valid_q;
  logic        flush_q;
  logic        pipe_halt_q;
  logic        halted_q;
  logic [15:0] pc_inc_d;

`ifdef PC_FETCH_WAIT_TIMEOUT_EN
  logic [3:0]  wait_cnt_q;
  logic        wait_timeout_q;
`endif

  // Modulo-2^16 increment shared by the sequencer and the PC_plus1 output.
  always_comb begin
    pc_inc_d = pc_q + 16'd1;
  end

  // Fetch sequencer: state, PC and all registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_RUN;
      pc_q           <= 16'h0000;
      fetch_valid_q  <= 1'b0;
      flush_q        <= 1'b0;
      pipe_halt_q    <= 1'b0;
      halted_q       <= 1'b0;
`ifdef PC_FETCH_WAIT_TIMEOUT_EN
      wait_cnt_q     <= 4'd0;
      wait_timeout_q <= 1'b0;
`endif
    end else begin
      // The flush is a single-cycle pulse; only a redirect re-arms it.
      flush_q <= 1'b0;
      case (state_q)
        ST_RUN: begin
          if (hlt_decoded) begin
            state_q       <= ST_HALT;
            fetch_valid_q <= 1'b0;
            pipe_halt_q   <= 1'b1;
            halted_q      <= 1'b1;
          end else if (cf_decoded) begin
            // PC already points at branch+1; hold it there while waiting.
            state_q       <= ST_WAIT;
            fetch_valid_q <= 1'b0;
            pipe_halt_q   <= 1'b1;
`ifdef PC_FETCH_WAIT_TIMEOUT_EN
            wait_cnt_q    <= 4'd0;
`endif
          end else begin
            fetch_valid_q <= 1'b1;
            pipe_halt_q   <= 1'b0;
            // Advance only once the current PC has been fetched validly, so
            // the first cycle after reset fetches address 0 before counting.
            if (!stall && fetch_valid_q) begin
              pc_q <= pc_inc_d;
            end
          end
        end

        ST_WAIT: begin
          // cf_decoded, hlt_decoded and stall are deliberately not looked at.
          if (PC_src && update_done) begin
            pc_q          <= PC_update;
            flush_q       <= 1'b1;
            state_q       <= ST_RUN;
            fetch_valid_q <= 1'b1;
            pipe_halt_q   <= 1'b0;
          end else if (alu_done && !PC_src) begin
            // Not taken: the held PC is already the fall-through address.
            state_q       <= ST_RUN;
            fetch_valid_q <= 1'b1;
            pipe_halt_q   <= 1'b0;
          end
`ifdef PC_FETCH_WAIT_TIMEOUT_EN
          else if (wait_cnt_q == 4'd14) begin
            // Counter reaches 15 this edge: give up, flag it, resume fetch.
            wait_cnt_q     <= 4'd15;
            wait_timeout_q <= 1'b1;
            state_q        <= ST_RUN;
            fetch_valid_q  <= 1'b1;
            pipe_halt_q    <= 1'b0;
          end else begin
            wait_cnt_q <= wait_cnt_q + 4'd1;
          end
`endif
        end

        ST_HALT: begin
          // Frozen; only reset leaves this state.
          fetch_valid_q <= 1'b0;
          pipe_halt_q   <= 1'b1;
          halted_q      <= 1'b1;
        end

        default: begin
          state_q       <= ST_RUN;
          fetch_valid_q <= 1'b0;
          pipe_halt_q   <= 1'b0;
          halted_q      <= 1'b0;
        end
      endcase
    end
  end

  assign PC          = pc_q;
  assign PC_plus1    = pc_inc_d;
  assign fetch_valid = fetch_valid_q;
  assign flush_IF_ID = flush_q;
  assign pipe_halt   = pipe_halt_q;
  assign halted      = halted_q;
`ifdef PC_FETCH_WAIT_TIMEOUT_EN
  assign wait_timeout = wait_timeout_q;
`endif

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed bench for pc_fetch_ctrl. Status word compared in most checks:
// {PC[15:0], fetch_valid, flush_IF_ID, pipe_halt, halted}.
`timescale 1ns/1ps
module tb_pc_fetch_ctrl;

  logic        clk;
  logic        rst_n;
  logic        cf_decoded;
  logic        alu_done;
  logic [15:0] PC_update;
  logic        PC_src;
  logic        update_done;
  logic        hlt_decoded;
  logic        stall;
  logic [15:0] PC;
  logic [15:0] PC_plus1;
  logic        fetch_valid;
  logic        flush_IF_ID;
  logic        pipe_halt;
  logic        halted;
`ifdef PC_FETCH_WAIT_TIMEOUT_EN
  logic        wait_timeout;
`endif

  logic [19:0] st;
  int vectors;
  int miscompares;

  pc_fetch_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cf_decoded  (cf_decoded),
    .alu_done    (alu_done),
    .PC_update   (PC_update),
    .PC_src      (PC_src),
    .update_done (update_done),
    .hlt_decoded (hlt_decoded),
    .stall       (stall),
    .PC          (PC),
    .PC_plus1    (PC_plus1),
    .fetch_valid (fetch_valid),
    .flush_IF_ID (flush_IF_ID),
    .pipe_halt   (pipe_halt),
    .halted      (halted)
`ifdef PC_FETCH_WAIT_TIMEOUT_EN
    ,
    .wait_timeout(wait_timeout)
`endif
  );

  assign st = {PC, fetch_valid, flush_IF_ID, pipe_halt, halted};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One rising edge, then settle so outputs are sampled away from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    cf_decoded  = 1'b0;
    alu_done    = 1'b0;
    PC_update   = 16'h0000;
    PC_src      = 1'b0;
    update_done = 1'b0;
    hlt_decoded = 1'b0;
    stall       = 1'b0;
  endtask

  // Reset, release, first fetch at 0, then n increments so PC == n.
  task automatic reset_to(input int n);
    clear_inputs();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_n = 1'b0;
    #1;
    vectors++;
    if (st !== {16'h0000, 4'b0000}) begin
      miscompares++;
      $display("FAIL reset_state: got %h expected %h", st, {16'h0000, 4'b0000});
    end
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      vectors++;
      if (st !== {i[15:0], 4'b1000}) begin
        miscompares++;
        $display("FAIL free_run[%0d]: got %h expected %h", i, st, {i[15:0], 4'b1000});
      end
    end
    $display("test_reset: free run 0x0000..0x0004 observed");
  endtask

  task automatic test_redirect();
    reset_to(16);
    cf_decoded = 1'b1;
    tick();
    cf_decoded = 1'b0;
    vectors++;
    if (st !== {16'h0010, 4'b0010}) begin
      miscompares++;
      $display("FAIL redirect_bubble1: got %h expected %h", st, {16'h0010, 4'b0010});
    end
    tick();
    vectors++;
    if (st !== {16'h0010, 4'b0010}) begin
      miscompares++;
      $display("FAIL redirect_bubble2: got %h expected %h", st, {16'h0010, 4'b0010});
    end
    PC_src = 1'b1; update_done = 1'b1; PC_update = 16'h0040;
    tick();
    clear_inputs();
    vectors++;
    if (st !== {16'h0040, 4'b1100}) begin
      miscompares++;
      $display("FAIL redirect_target: got %h expected %h", st, {16'h0040, 4'b1100});
    end
    tick();
    vectors++;
    if (st !== {16'h0041, 4'b1000}) begin
      miscompares++;
      $display("FAIL redirect_next: got %h expected %h", st, {16'h0041, 4'b1000});
    end
    $display("test_redirect: 0x0010 -> 0x0040 with flush");
  endtask

  task automatic test_not_taken();
    reset_to(16);
    cf_decoded = 1'b1;
    tick();
    // Inputs that must be ignored while waiting.
    hlt_decoded = 1'b1; stall = 1'b1;
    tick();
    clear_inputs();
    vectors++;
    if (st !== {16'h0010, 4'b0010}) begin
      miscompares++;
      $display("FAIL wait_ignores: got %h expected %h", st, {16'h0010, 4'b0010});
    end
    alu_done = 1'b1;
    tick();
    clear_inputs();
    vectors++;
    if (st !== {16'h0010, 4'b1000}) begin
      miscompares++;
      $display("FAIL not_taken_resume: got %h expected %h", st, {16'h0010, 4'b1000});
    end
    tick();
    vectors++;
    if (st !== {16'h0011, 4'b1000}) begin
      miscompares++;
      $display("FAIL not_taken_next: got %h expected %h", st, {16'h0011, 4'b1000});
    end
    $display("test_not_taken: resume at 0x0010 then 0x0011");
  endtask

  task automatic test_stall();
    reset_to(3);
    stall = 1'b1;
    tick();
    tick();
    vectors++;
    if (st !== {16'h0003, 4'b1000}) begin
      miscompares++;
      $display("FAIL stall_hold: got %h expected %h", st, {16'h0003, 4'b1000});
    end
    stall = 1'b0;
    tick();
    vectors++;
    if (st !== {16'h0004, 4'b1000}) begin
      miscompares++;
      $display("FAIL stall_release: got %h expected %h", st, {16'h0004, 4'b1000});
    end
    $display("test_stall: PC held at 0x0003 then 0x0004");
  endtask

  task automatic test_wrap();
    reset_to(1);
    cf_decoded = 1'b1;
    tick();
    clear_inputs();
    PC_src = 1'b1; update_done = 1'b1; PC_update = 16'hFFFF;
    tick();
    clear_inputs();
    vectors++;
    if ({PC, PC_plus1} !== {16'hFFFF, 16'h0000}) begin
      miscompares++;
      $display("FAIL wrap_plus1: got %h expected %h", {PC, PC_plus1}, {16'hFFFF, 16'h0000});
    end
    tick();
    vectors++;
    if (st !== {16'h0000, 4'b1000}) begin
      miscompares++;
      $display("FAIL wrap_pc: got %h expected %h", st, {16'h0000, 4'b1000});
    end
    $display("test_wrap: 0xFFFF -> 0x0000");
  endtask

  task automatic test_halt();
    reset_to(5);
    hlt_decoded = 1'b1;
    tick();
    hlt_decoded = 1'b0;
    for (int i = 0; i < 20; i++) begin
      vectors++;
      if (st !== {16'h0005, 4'b0011}) begin
        miscompares++;
        $display("FAIL halt_hold[%0d]: got %h expected %h", i, st, {16'h0005, 4'b0011});
      end
      stall = ~stall;
      cf_decoded = (i == 7);
      tick();
    end
    clear_inputs();
    rst_n = 1'b0;
    #1;
    vectors++;
    if (st !== {16'h0000, 4'b0000}) begin
      miscompares++;
      $display("FAIL halt_reset: got %h expected %h", st, {16'h0000, 4'b0000});
    end
    tick();
    rst_n = 1'b1;
    $display("test_halt: PC frozen at 0x0005 for 20 cycles");
  endtask

  task automatic test_redirect_wins();
    reset_to(2);
    cf_decoded = 1'b1;
    tick();
    clear_inputs();
    PC_src = 1'b1; update_done = 1'b1; PC_update = 16'h0100;
    hlt_decoded = 1'b1; alu_done = 1'b1; stall = 1'b1;
    tick();
    clear_inputs();
    vectors++;
    if (st !== {16'h0100, 4'b1100}) begin
      miscompares++;
      $display("FAIL redirect_wins: got %h expected %h", st, {16'h0100, 4'b1100});
    end
    tick();
    vectors++;
    if (st !== {16'h0101, 4'b1000}) begin
      miscompares++;
      $display("FAIL redirect_wins_next: got %h expected %h", st, {16'h0101, 4'b1000});
    end
    $display("test_redirect_wins: PC 0x0100, not halted");
  endtask

  task automatic test_reset_mid_wait();
    reset_to(4);
    cf_decoded = 1'b1;
    tick();
    clear_inputs();
    rst_n = 1'b0;
    #1;
    vectors++;
    if (st !== {16'h0000, 4'b0000}) begin
      miscompares++;
      $display("FAIL wait_reset: got %h expected %h", st, {16'h0000, 4'b0000});
    end
    PC_src = 1'b1; update_done = 1'b1; PC_update = 16'h0077;
    tick();
    clear_inputs();
    rst_n = 1'b1;
    tick();
    vectors++;
    if (st !== {16'h0000, 4'b1000}) begin
      miscompares++;
      $display("FAIL wait_reset_release: got %h expected %h", st, {16'h0000, 4'b1000});
    end
    $display("test_reset_mid_wait: redirect abandoned");
  endtask

`ifdef PC_FETCH_WAIT_TIMEOUT_EN
  task automatic test_timeout();
    reset_to(16);
    cf_decoded = 1'b1;
    tick();
    cf_decoded = 1'b0;
    for (int i = 1; i <= 14; i++) begin
      tick();
      vectors++;
      if ({wait_timeout, st} !== {1'b0, 16'h0010, 4'b0010}) begin
        miscompares++;
        $display("FAIL timeout_early[%0d]: got %h expected %h", i, {wait_timeout, st}, {1'b0, 16'h0010, 4'b0010});
      end
    end
    tick();
    vectors++;
    if ({wait_timeout, st} !== {1'b1, 16'h0010, 4'b1000}) begin
      miscompares++;
      $display("FAIL timeout_fire: got %h expected %h", {wait_timeout, st}, {1'b1, 16'h0010, 4'b1000});
    end
    cf_decoded = 1'b1;
    tick();
    cf_decoded = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({wait_timeout, st} !== {1'b0, 16'h0000, 4'b0000}) begin
      miscompares++;
      $display("FAIL timeout_reset: got %h expected %h", {wait_timeout, st}, {1'b0, 16'h0000, 4'b0000});
    end
    tick();
    rst_n = 1'b1;
    $display("test_timeout: flag set after 15 wait cycles, cleared by reset");
  endtask
`else
  task automatic test_wait_persists();
    reset_to(16);
    cf_decoded = 1'b1;
    tick();
    cf_decoded = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    vectors++;
    if (st !== {16'h0010, 4'b0010}) begin
      miscompares++;
      $display("FAIL wait_persists: got %h expected %h", st, {16'h0010, 4'b0010});
    end
    alu_done = 1'b1;
    tick();
    clear_inputs();
    $display("test_wait_persists: still waiting after 20 cycles");
  endtask
`endif

  initial begin
    vectors = 0;
    miscompares = 0;
    rst_n = 1'b0;
    clear_inputs();
    test_reset();
    test_redirect();
    test_not_taken();
    test_stall();
    test_wrap();
    test_halt();
    test_redirect_wins();
    test_reset_mid_wait();
`ifdef PC_FETCH_WAIT_TIMEOUT_EN
    test_timeout();
`else
    test_wait_persists();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
